// File: rtl/eluks_boot_dma_pkg.sv
// Shared types and constants for the ELUKS boot DMA engine.
// Contents: top-level sequencer states, transfer-engine states, error codes,
// ELUKS register offsets and the ordering of the configuration writes.
package eluks_boot_pkg;

  typedef enum logic [3:0] {
    S_BUS_RST,
    S_IDLE,
    S_CFG,
    S_STATUS,
    S_COPY_RD,
    S_COPY_WR,
    S_DONE,
    S_ERROR
  } boot_state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_ADDR,
    X_BUS,
    X_WAIT_NACK
  } xfer_state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ELUKS    = 3'd1,
    ERR_BUS      = 3'd2,
    ERR_RETRY    = 3'd3,
    ERR_ZERO_LEN = 3'd4
  } err_code_t;

  localparam int unsigned REG_PSW0      = 0;
  localparam int unsigned REG_PSW1      = 1;
  localparam int unsigned REG_START     = 2;
  localparam int unsigned REG_BDIR      = 3;
  localparam int unsigned REG_HMAC      = 4;
  localparam int unsigned REG_RQ_DATA   = 5;
  localparam int unsigned REG_RQ_STATUS = 6;

  // Configuration write order: HMAC is programmed before BDIR, and the
  // sequence ends with the RQ_STATUS kick.
  function automatic int unsigned cfg_reg(input logic [2:0] idx);
    case (idx)
      3'd0:    return REG_PSW0;
      3'd1:    return REG_PSW1;
      3'd2:    return REG_START;
      3'd3:    return REG_HMAC;
      3'd4:    return REG_BDIR;
      default: return REG_RQ_STATUS;
    endcase
  endfunction

endpackage

// File: rtl/eluks_boot_dma_xfer.sv
// Single Wishbone classic-cycle transfer engine.
// A one-cycle req latches address/data/direction; the engine then runs
// ADDR -> BUS -> WAIT_NACK, retrying on rty or ack timeout, and answers
// with a one-cycle done (rd_dat valid) or fail (fail_retry: 1 = retries
// exhausted, 0 = bus error).
// Ports: wb_clk, rst (sync, active-high); req/req_we/req_adr/req_dat in;
// done/fail/fail_retry/rd_dat out; wb_adr_o/wb_dat_o/wb_cyc_o/wb_stb_o/
// wb_we_o out; wb_dat_i/wb_ack_i/wb_err_i/wb_rty_i in.
//
// state       | meaning
// X_IDLE      | waiting for req
// X_ADDR      | drive address/data, raise cyc/stb, load timeout
// X_BUS       | cyc/stb high until err, rty, ack or timeout
// X_WAIT_NACK | bus released, wait for ack low before next attempt/result
module eluks_wb_xfer
  import eluks_boot_pkg::*;
#(
  parameter int WB_DATA     = 32,
  parameter int ACK_TIMEOUT = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic               wb_clk,
  input  logic               rst,
  input  logic               req,
  input  logic               req_we,
  input  logic [WB_DATA-1:0] req_adr,
  input  logic [WB_DATA-1:0] req_dat,
  output logic               done,
  output logic               fail,
  output logic               fail_retry,
  output logic [WB_DATA-1:0] rd_dat,
  output logic [WB_DATA-1:0] wb_adr_o,
  output logic [WB_DATA-1:0] wb_dat_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  input  logic [WB_DATA-1:0] wb_dat_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i,
  input  logic               wb_rty_i
);

  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  xfer_state_t        state;
  logic [WB_DATA-1:0] adr_q;
  logic [WB_DATA-1:0] dat_q;
  logic               we_q;
  logic [TMR_W-1:0]   timer;
  logic [RTY_W-1:0]   retry_cnt;
  logic               retry_pend;

  always_ff @(posedge wb_clk) begin
    if (rst) begin
      state      <= X_IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      timer      <= '0;
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_retry <= 1'b0;
      rd_dat     <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        X_IDLE: begin
          if (req) begin
            adr_q     <= req_adr;
            dat_q     <= req_dat;
            we_q      <= req_we;
            retry_cnt <= '0;
            state     <= X_ADDR;
          end
        end
        X_ADDR: begin
          wb_adr_o <= adr_q;
          wb_dat_o <= dat_q;
          wb_we_o  <= we_q;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          timer    <= TMR_W'(ACK_TIMEOUT - 1);
          state    <= X_BUS;
        end
        X_BUS: begin
          // err wins over rty, rty over ack; a timeout is only taken when
          // the slave gave no termination at all this cycle.
          if (wb_err_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            fail       <= 1'b1;
            fail_retry <= 1'b0;
            state      <= X_IDLE;
          end else if (wb_rty_i || (!wb_ack_i && timer == '0)) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (retry_cnt == RTY_W'(MAX_RETRY)) begin
              fail       <= 1'b1;
              fail_retry <= 1'b1;
              state      <= X_IDLE;
            end else begin
              retry_cnt  <= retry_cnt + 1'b1;
              retry_pend <= 1'b1;
              state      <= X_WAIT_NACK;
            end
          end else if (wb_ack_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            rd_dat     <= wb_dat_i;
            retry_pend <= 1'b0;
            state      <= X_WAIT_NACK;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        X_WAIT_NACK: begin
          if (!wb_ack_i) begin
            if (retry_pend) begin
              state <= X_ADDR;
            end else begin
              done  <= 1'b1;
              state <= X_IDLE;
            end
          end
        end
        default: state <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/eluks_boot_dma.sv
// ELUKS boot engine: holds the CPU in reset, programs the ELUKS core over
// Wishbone, streams decrypted bytes, packs them MSB-first into words and
// writes the boot image to RAM, then releases the CPU.
// Ports: wb_clk, rst (sync, active-high); Wishbone master (wb_adr_o,
// wb_dat_o, wb_dat_i, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o,
// wb_bte_o, wb_ack_i, wb_err_i, wb_rty_i); start, psw, start_block,
// hmac_enable in; cpu_rst, bus_rst, done, error, err_code, words_copied out.
//
// state     | meaning
// S_BUS_RST | bus_rst pulse after rst
// S_IDLE    | CPU in reset, counters cleared, wait for start
// S_CFG     | ELUKS register writes, ending with the RQ_STATUS kick
// S_STATUS  | read RQ_STATUS, derive image length
// S_COPY_RD | read one RQ_DATA byte into the packing buffer
// S_COPY_WR | write the packed word to RAM
// S_DONE    | image copied, CPU released
// S_ERROR   | failure latched, CPU stays in reset
module eluks_boot_dma
  import eluks_boot_pkg::*;
#(
  parameter int          WB_DATA       = 32,
  parameter logic [31:0] ELUKS_WB_ADDR = 32'h9200_0000,
  parameter logic [31:0] RAM_WB_ADDR   = 32'h0,
  parameter int          BLOCK_BYTES   = 512,
  parameter int          RST_CYCLES    = 16,
  parameter int          ACK_TIMEOUT   = 1024,
  parameter int          MAX_RETRY     = 3
) (
  input  logic                   wb_clk,
  input  logic                   rst,
  output logic [WB_DATA-1:0]     wb_adr_o,
  output logic [WB_DATA-1:0]     wb_dat_o,
  input  logic [WB_DATA-1:0]     wb_dat_i,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [WB_DATA/8-1:0]   wb_sel_o,
  output logic [2:0]             wb_cti_o,
  output logic [1:0]             wb_bte_o,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  input  logic                   wb_rty_i,
  input  logic                   start,
  input  logic [63:0]            psw,
  input  logic [31:0]            start_block,
  input  logic                   hmac_enable,
  output logic                   cpu_rst,
  output logic                   bus_rst,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             err_code,
  output logic [31:0]            words_copied
);

  localparam int unsigned BPW   = WB_DATA / 8;
  localparam int unsigned WPB   = BLOCK_BYTES / BPW;
  localparam int          RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [WB_DATA-1:0] ELUKS_BASE = WB_DATA'(ELUKS_WB_ADDR);
  localparam logic [WB_DATA-1:0] RAM_BASE   = WB_DATA'(RAM_WB_ADDR);

  boot_state_t        state;
  err_code_t          err_code_q;
  logic [RST_W-1:0]   rst_cnt;
  logic [2:0]         cfg_idx;
  logic [7:0]         byte_idx;
  logic [WB_DATA-1:0] word_buf;
  logic [31:0]        total_words;
  logic               pending;

  logic               req;
  logic               req_we;
  logic [WB_DATA-1:0] req_adr;
  logic [WB_DATA-1:0] req_dat;
  logic               x_done;
  logic               x_fail;
  logic               x_fail_retry;
  logic [WB_DATA-1:0] x_rd_dat;

  logic               issue_state;
  logic               nxt_we;
  logic [WB_DATA-1:0] nxt_adr;
  logic [WB_DATA-1:0] nxt_dat;

  assign wb_sel_o = {BPW{wb_stb_o}};
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;
  assign err_code = err_code_q;

  eluks_wb_xfer #(
    .WB_DATA     (WB_DATA),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) u_xfer (
    .wb_clk     (wb_clk),
    .rst        (rst),
    .req        (req),
    .req_we     (req_we),
    .req_adr    (req_adr),
    .req_dat    (req_dat),
    .done       (x_done),
    .fail       (x_fail),
    .fail_retry (x_fail_retry),
    .rd_dat     (x_rd_dat),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_rty_i   (wb_rty_i)
  );

  // Next transfer for the current sequencer step.
  always_comb begin
    issue_state = 1'b0;
    nxt_we      = 1'b0;
    nxt_adr     = ELUKS_BASE;
    nxt_dat     = '0;
    case (state)
      S_CFG: begin
        issue_state = 1'b1;
        nxt_we      = 1'b1;
        nxt_adr     = ELUKS_BASE + WB_DATA'(cfg_reg(cfg_idx));
        case (cfg_idx)
          3'd0:    nxt_dat = WB_DATA'(psw[63:32]);
          3'd1:    nxt_dat = WB_DATA'(psw[31:0]);
          3'd2:    nxt_dat = WB_DATA'(start_block);
          3'd3:    nxt_dat = WB_DATA'(hmac_enable);
          3'd4:    nxt_dat = WB_DATA'(start_block);
          default: nxt_dat = WB_DATA'(1);
        endcase
      end
      S_STATUS: begin
        issue_state = 1'b1;
        nxt_adr     = ELUKS_BASE + WB_DATA'(REG_RQ_STATUS);
      end
      S_COPY_RD: begin
        issue_state = 1'b1;
        nxt_adr     = ELUKS_BASE + WB_DATA'(REG_RQ_DATA);
      end
      S_COPY_WR: begin
        issue_state = 1'b1;
        nxt_we      = 1'b1;
        nxt_adr     = RAM_BASE + WB_DATA'(words_copied * 32'(BPW));
        nxt_dat     = word_buf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (rst) begin
      state        <= S_BUS_RST;
      err_code_q   <= ERR_NONE;
      rst_cnt      <= RST_W'(RST_CYCLES);
      cfg_idx      <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      total_words  <= '0;
      pending      <= 1'b0;
      req          <= 1'b0;
      req_we       <= 1'b0;
      req_adr      <= '0;
      req_dat      <= '0;
      cpu_rst      <= 1'b1;
      bus_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_copied <= '0;
    end else begin
      req <= 1'b0;
      if (x_fail) begin
        state      <= S_ERROR;
        err_code_q <= x_fail_retry ? ERR_RETRY : ERR_BUS;
        error      <= 1'b1;
        pending    <= 1'b0;
      end else begin
        if (issue_state && !pending) begin
          req     <= 1'b1;
          pending <= 1'b1;
          req_we  <= nxt_we;
          req_adr <= nxt_adr;
          req_dat <= nxt_dat;
        end
        if (x_done) pending <= 1'b0;

        case (state)
          S_BUS_RST: begin
            if (rst_cnt == '0) begin
              bus_rst <= 1'b0;
              state   <= S_IDLE;
            end else begin
              rst_cnt <= rst_cnt - 1'b1;
            end
          end
          S_IDLE: begin
            cpu_rst      <= 1'b1;
            words_copied <= '0;
            total_words  <= '0;
            cfg_idx      <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            if (start) state <= S_CFG;
          end
          S_CFG: begin
            if (x_done) begin
              if (cfg_idx == 3'd5) state <= S_STATUS;
              else cfg_idx <= cfg_idx + 3'd1;
            end
          end
          S_STATUS: begin
            if (x_done) begin
              if (x_rd_dat[WB_DATA-1]) begin
                state      <= S_ERROR;
                err_code_q <= ERR_ELUKS;
                error      <= 1'b1;
              end else if (x_rd_dat[WB_DATA-2:0] == '0) begin
                state      <= S_ERROR;
                err_code_q <= ERR_ZERO_LEN;
                error      <= 1'b1;
              end else begin
                total_words <= 32'(x_rd_dat[WB_DATA-2:0]) * 32'(WPB);
                state       <= S_COPY_RD;
              end
            end
          end
          S_COPY_RD: begin
            if (x_done) begin
              // Shifting left makes the first byte of a word end up in the MSBs.
              word_buf <= (word_buf << 8) | WB_DATA'(x_rd_dat[7:0]);
              if (byte_idx == 8'(BPW - 1)) begin
                byte_idx <= '0;
                state    <= S_COPY_WR;
              end else begin
                byte_idx <= byte_idx + 8'd1;
              end
            end
          end
          S_COPY_WR: begin
            if (x_done) begin
              words_copied <= words_copied + 32'd1;
              if ((words_copied + 32'd1) == total_words) begin
                state   <= S_DONE;
                cpu_rst <= 1'b0;
                done    <= 1'b1;
              end else begin
                state <= S_COPY_RD;
              end
            end
          end
          S_DONE: begin
            cpu_rst <= 1'b0;
            done    <= 1'b1;
          end
          S_ERROR: begin
            cpu_rst <= 1'b1;
            error   <= 1'b1;
          end
          default: state <= S_BUS_RST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eluks_boot_dma.sv
// Self-checking bench for eluks_boot_dma: a Wishbone slave model that plays
// ELUKS and RAM (with injectable err/rty/no-response per attempt) and a
// reference model that rebuilds the expected register writes and RAM image
// from the boot parameters and the byte stream handed to the slave.
module tb_eluks_boot_dma;

  localparam logic [31:0] EBASE = 32'h9200_0000;

  logic        wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  logic        rst;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic        start;
  logic [63:0] psw;
  logic [31:0] start_block;
  logic        hmac_enable;
  logic        cpu_rst, bus_rst, done, error;
  logic [2:0]  err_code;
  logic [31:0] words_copied;

  eluks_boot_dma dut (
    .wb_clk       (wb_clk),
    .rst          (rst),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_sel_o     (wb_sel_o),
    .wb_cti_o     (wb_cti_o),
    .wb_bte_o     (wb_bte_o),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i),
    .wb_rty_i     (wb_rty_i),
    .start        (start),
    .psw          (psw),
    .start_block  (start_block),
    .hmac_enable  (hmac_enable),
    .cpu_rst      (cpu_rst),
    .bus_rst      (bus_rst),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .words_copied (words_copied)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  wr_t         eluks_wr[$];
  wr_t         ram_wr[$];
  logic [7:0]  byte_q[$];
  logic [7:0]  exp_bytes[$];
  logic [31:0] status_val;
  logic [31:0] inj_adr;
  logic        inj_we;
  int          inj_codes[$];   // per attempt: 0 ack, 1 err, 2 rty, 3 no response
  int          max_delay;
  int          rq_reads;
  int          bus_bad;
  bit          in_att;
  bit          responded;
  int          att_code;
  int          att_delay;

  always @(negedge wb_clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    if (wb_stb_o && wb_sel_o != 4'hF) bus_bad++;
    if (wb_cti_o != 3'd0 || wb_bte_o != 2'd0) bus_bad++;
    if (rst || !(wb_cyc_o && wb_stb_o)) begin
      in_att    = 1'b0;
      responded = 1'b0;
    end else begin
      if (!in_att) begin
        in_att    = 1'b1;
        responded = 1'b0;
        att_delay = $urandom_range(0, max_delay);
        att_code  = 0;
        if (inj_codes.size() != 0 && wb_adr_o == inj_adr && wb_we_o == inj_we)
          att_code = inj_codes.pop_front();
        if (!wb_we_o && wb_adr_o == EBASE + 32'd5) rq_reads++;
      end
      if (!responded && att_code != 3) begin
        if (att_delay > 0) begin
          att_delay--;
        end else begin
          responded = 1'b1;
          case (att_code)
            1: wb_err_i = 1'b1;
            2: wb_rty_i = 1'b1;
            default: begin
              wb_ack_i = 1'b1;
              if (wb_we_o) begin
                if (wb_adr_o >= EBASE) eluks_wr.push_back('{wb_adr_o, wb_dat_o});
                else ram_wr.push_back('{wb_adr_o, wb_dat_o});
              end else if (wb_adr_o == EBASE + 32'd6) begin
                wb_dat_i = status_val;
              end else if (wb_adr_o == EBASE + 32'd5) begin
                if (byte_q.size() != 0) wb_dat_i = {24'h0, byte_q.pop_front()};
                else wb_dat_i = 32'h0;
              end else begin
                wb_dat_i = 32'hDEAD_BEEF;
              end
            end
          endcase
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_env();
    eluks_wr.delete();
    ram_wr.delete();
    byte_q.delete();
    exp_bytes.delete();
    inj_codes.delete();
    rq_reads = 0;
  endtask

  task automatic count_bus_rst(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge wb_clk);
      if (bus_rst) n++;
      else break;
    end
  endtask

  task automatic do_reset();
    int n;
    @(negedge wb_clk);
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge wb_clk);
    rst = 1'b0;
    count_bus_rst(n);
    clear_env();
  endtask

  // pattern 0: 00..FF repeating, 1: random
  task automatic load_bytes(input int blocks, input int pattern);
    logic [7:0] b;
    for (int i = 0; i < blocks * 512; i++) begin
      b = (pattern == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      byte_q.push_back(b);
      exp_bytes.push_back(b);
    end
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(done || error) && n < 60000) begin
      @(negedge wb_clk);
      n++;
    end
    chk({tag, " finished"}, 64'(done || error), 64'd1);
  endtask

  // Expected register writes and RAM image derived from the boot inputs.
  task automatic check_run(input string tag, input logic [63:0] p, input logic [31:0] sb,
                           input logic h, input int blocks);
    logic [31:0] ea[6];
    logic [31:0] ed[6];
    logic [31:0] exp_word;
    int          n_words;
    int          bad;
    ea[0] = EBASE + 0; ed[0] = p[63:32];
    ea[1] = EBASE + 1; ed[1] = p[31:0];
    ea[2] = EBASE + 2; ed[2] = sb;
    ea[3] = EBASE + 4; ed[3] = {31'b0, h};
    ea[4] = EBASE + 3; ed[4] = sb;
    ea[5] = EBASE + 6; ed[5] = 32'd1;
    chk({tag, " cfg write count"}, 64'(eluks_wr.size()), 64'd6);
    bad = 0;
    for (int i = 0; i < 6 && i < eluks_wr.size(); i++)
      if (eluks_wr[i].adr !== ea[i] || eluks_wr[i].dat !== ed[i]) bad++;
    chk({tag, " cfg write mismatches"}, 64'(bad), 64'd0);
    n_words = blocks * 512 / 4;
    chk({tag, " ram write count"}, 64'(ram_wr.size()), 64'(n_words));
    bad = 0;
    for (int i = 0; i < ram_wr.size(); i++) begin
      if (4 * i + 3 < exp_bytes.size())
        exp_word = {exp_bytes[4*i], exp_bytes[4*i+1], exp_bytes[4*i+2], exp_bytes[4*i+3]};
      else
        exp_word = 32'hx;
      if (ram_wr[i].adr !== 32'(4 * i) || ram_wr[i].dat !== exp_word) bad++;
    end
    chk({tag, " ram image mismatches"}, 64'(bad), 64'd0);
    chk({tag, " rq_data reads"}, 64'(rq_reads), 64'(blocks * 512));
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " cpu_rst"}, 64'(cpu_rst), 64'd0);
    chk({tag, " error"}, 64'(error), 64'd0);
    chk({tag, " words_copied"}, 64'(words_copied), 64'(n_words));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [63:0] rp;
    logic [31:0] rsb;
    logic        rh;

    rst = 1'b1; start = 1'b0; psw = '0; start_block = '0; hmac_enable = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    max_delay = 0; status_val = 32'd1; inj_adr = '0; inj_we = 1'b0;
    rq_reads = 0; bus_bad = 0; in_att = 1'b0; responded = 1'b0;
    att_code = 0; att_delay = 0;
    repeat (3) @(negedge wb_clk);

    chk("reset cyc", 64'(wb_cyc_o), 64'd0);
    chk("reset stb", 64'(wb_stb_o), 64'd0);
    chk("reset we", 64'(wb_we_o), 64'd0);
    chk("reset adr", 64'(wb_adr_o), 64'd0);
    chk("reset dat", 64'(wb_dat_o), 64'd0);
    chk("reset cpu_rst", 64'(cpu_rst), 64'd1);
    chk("reset bus_rst", 64'(bus_rst), 64'd1);
    chk("reset done", 64'(done), 64'd0);
    chk("reset error", 64'(error), 64'd0);
    chk("reset err_code", 64'(err_code), 64'd0);
    chk("reset words_copied", 64'(words_copied), 64'd0);
    rst = 1'b0;
    count_bus_rst(n);
    chk("bus_rst length", 64'(n), 64'd16);
    repeat (8) @(negedge wb_clk);
    chk("idle without start cyc", 64'(wb_cyc_o), 64'd0);
    clear_env();

    // Reference boot: known password and counting byte stream.
    psw = 64'h0123_4567_89AB_CDEF; start_block = 32'd8; hmac_enable = 1'b1;
    status_val = 32'd1;
    load_bytes(1, 0);
    start = 1'b1;
    wait_end("basic");
    check_run("basic", psw, start_block, hmac_enable, 1);
    chk("basic first word", 64'(ram_wr.size() > 0 ? ram_wr[0].dat : 32'hx), 64'h0001_0203);
    chk("basic last addr", 64'(ram_wr.size() > 0 ? ram_wr[ram_wr.size()-1].adr : 32'hx), 64'd508);

    // Randomized boots with random slave latency.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      rp = {$urandom, $urandom}; rsb = $urandom; rh = 1'($urandom_range(0, 1));
      psw = rp; start_block = rsb; hmac_enable = rh;
      max_delay = 3; status_val = 32'd1;
      load_bytes(1, 1);
      start = 1'b1;
      wait_end("random");
      check_run("random", rp, rsb, rh, 1);
    end
    max_delay = 0;

    // ELUKS reports an error in the status word.
    do_reset();
    status_val = 32'h8000_0001;
    start = 1'b1;
    wait_end("eluks err");
    chk("eluks err error", 64'(error), 64'd1);
    chk("eluks err code", 64'(err_code), 64'd1);
    chk("eluks err cpu_rst", 64'(cpu_rst), 64'd1);
    chk("eluks err done", 64'(done), 64'd0);
    chk("eluks err rq reads", 64'(rq_reads), 64'd0);

    // Bus error on the PSW1 write.
    do_reset();
    status_val = 32'd1;
    inj_adr = EBASE + 32'd1; inj_we = 1'b1; inj_codes.push_back(1);
    start = 1'b1;
    wait_end("bus err");
    chk("bus err code", 64'(err_code), 64'd2);
    chk("bus err cyc idle", 64'(wb_cyc_o), 64'd0);
    chk("bus err cfg writes", 64'(eluks_wr.size()), 64'd1);
    chk("bus err cpu_rst", 64'(cpu_rst), 64'd1);

    // Zero-length image.
    do_reset();
    status_val = 32'd0;
    start = 1'b1;
    wait_end("zero len");
    chk("zero len code", 64'(err_code), 64'd4);
    chk("zero len rq reads", 64'(rq_reads), 64'd0);

    // Two rty on the first RAM write, then ack.
    do_reset();
    status_val = 32'd1;
    load_bytes(1, 0);
    inj_adr = 32'h0; inj_we = 1'b1; inj_codes.push_back(2); inj_codes.push_back(2);
    start = 1'b1;
    wait_end("rty");
    check_run("rty", psw, start_block, hmac_enable, 1);

    // Four timeouts in a row on PSW0 exhaust the retries.
    do_reset();
    status_val = 32'd1;
    inj_adr = EBASE; inj_we = 1'b1;
    repeat (4) inj_codes.push_back(3);
    start = 1'b1;
    wait_end("timeout");
    chk("timeout code", 64'(err_code), 64'd3);
    chk("timeout cfg writes", 64'(eluks_wr.size()), 64'd0);
    chk("timeout cyc idle", 64'(wb_cyc_o), 64'd0);

    // Three timeouts then ack on HMAC still succeed; status then flags ELUKS error.
    do_reset();
    status_val = 32'h8000_0002;
    inj_adr = EBASE + 32'd4; inj_we = 1'b1;
    repeat (3) inj_codes.push_back(3);
    start = 1'b1;
    wait_end("timeout recover");
    chk("timeout recover code", 64'(err_code), 64'd1);
    chk("timeout recover cfg writes", 64'(eluks_wr.size()), 64'd6);

    // Reset in the middle of the copy, then a clean reboot.
    do_reset();
    status_val = 32'd1;
    load_bytes(1, 0);
    start = 1'b1;
    n = 0;
    while (words_copied < 32'd10 && n < 20000) begin
      @(negedge wb_clk);
      n++;
    end
    chk("midrst reached copy", 64'(words_copied >= 32'd10), 64'd1);
    while (!wb_cyc_o && n < 20000) begin
      @(negedge wb_clk);
      n++;
    end
    rst = 1'b1;
    @(negedge wb_clk);
    chk("midrst cyc drop", 64'(wb_cyc_o), 64'd0);
    chk("midrst words_copied", 64'(words_copied), 64'd0);
    chk("midrst cpu_rst", 64'(cpu_rst), 64'd1);
    start = 1'b0;
    rst = 1'b0;
    count_bus_rst(n);
    chk("midrst bus_rst length", 64'(n), 64'd16);
    repeat (8) @(negedge wb_clk);
    chk("midrst idle cyc", 64'(wb_cyc_o), 64'd0);
    clear_env();
    load_bytes(1, 0);
    start = 1'b1;
    wait_end("reboot");
    check_run("reboot", psw, start_block, hmac_enable, 1);

    chk("sel/cti/bte violations", 64'(bus_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
